note_scroller: RTL and testbench
================================

// Module: note_scroller
// PURPOSE
//  Consumes the one-cycle tick from the rate divider and scrolls two note lanes (red/don, blue/ka) toward the hit slot.
//  Notes come from a chart source over a valid/ready handshake.
//  Player key pulses are judged against the hit slot, and the block keeps score and combo.
//  Sits between the rate divider / chart ROM reader and the VGA lane renderer / score display.
// PARAMETERS
//  LANE_LEN  16  slots per lane; notes enter at bit LANE_LEN-1 and are judged at bit 0
//  SCORE_W   16  score counter width
// PORTS
//  clock        in   1         system clock (CLOCK_50)
//  reset        in   1         asynchronous, active-high reset
//  tick         in   1         one-cycle scroll pulse from the rate divider
//  start        in   1         pulse; starts a song from IDLE or DONE
//  pause        in   1         pulse; toggles RUN<->PAUSED
//  chart_valid  in   1         chart_note/chart_last valid
//  chart_note   in   2         bit0=red, bit1=blue (both set = both lanes)
//  chart_last   in   1         this note is the final chart entry
//  chart_ready  out  1         chart entry accepted this cycle
//  hit_red      in   1         one-cycle red key press
//  hit_blue     in   1         one-cycle blue key press
//  lane_red     out  LANE_LEN  red lane contents
//  lane_blue    out  LANE_LEN  blue lane contents
//  score        out  SCORE_W   hit count, saturating
//  combo        out  8         consecutive hits, saturating at 255
//  hit_pulse    out  1         >=1 note hit this cycle
//  miss_pulse   out  1         >=1 note scrolled out unhit this cycle
//  done         out  1         high while in DONE
// BEHAVIOUR
//  Reset: all outputs and registers are 0; state = IDLE. Reset mid-song aborts immediately.
//  All outputs are registered; the effect of an input is visible the cycle after it is sampled.
//  States: IDLE, RUN, PAUSED, DRAIN, DONE.
//   IDLE:   lanes 0. start -> RUN, clearing score and combo.
//   RUN:    tick -> shift both lanes right by 1; bit LANE_LEN-1 takes chart_note if chart_valid, else 0 (no stall).
//           chart_ready = tick (combinational, RUN only).
//           Accepting an entry with chart_last=1 -> DRAIN.
//           pause -> PAUSED (pause wins over tick in the same cycle; no shift).
//   PAUSED: ticks, keys and chart are ignored; chart_ready=0; lanes are frozen. pause -> RUN.
//   DRAIN:  tick shifts 0 in; chart_ready=0; keys are still judged. Both lanes all zero -> DONE. pause is ignored.
//   DONE:   done=1; lanes are 0. start -> RUN, clearing score and combo.
//   start is ignored in RUN, PAUSED and DRAIN.
//  Judging (RUN and DRAIN only), using the pre-shift bit 0:
//   - hit_red with lane_red[0]=1 -> red hit; the note is removed and does not count as a miss. Same for blue.
//   - A press with no matching note at bit 0 is ignored, with no penalty.
//   - tick with an unhit note at bit 0 -> miss for that note.
//   - Same-cycle tick and hit on a bit-0 note -> hit, not miss.
//   - score += number of hits (0..2), saturating at all ones.
//   - combo_next = any miss ? 0 : sat255(combo + hits). A hit plus a miss in the same cycle gives combo=0.
//   - hit_pulse / miss_pulse are one cycle wide and may both be high in the same cycle.
// TESTING (LANE_LEN=4 unless noted)
//  1. start, chart {01, last}, 4 ticks -> lane_red 1000,0100,0010,0001; state DRAIN; chart_ready was high only on tick 1.
//  2. From 1, hit_red -> hit_pulse=1, score=1, combo=1, lane_red=0000, then done=1. Repeat with tick in the same cycle as hit_red -> hit, miss_pulse=0.
//  3. From 1, no press, 5th tick -> miss_pulse=1, combo=0, score=0, then done=1. hit_blue on a red note -> ignored.
//  4. RUN with lanes nonzero, pause, 3 ticks -> lanes unchanged, chart_ready=0. pause again, tick -> shift resumes.
//  5. chart_valid=0 on a tick -> 0 inserted, no stall. Assert reset mid-RUN -> all outputs 0 at once, state IDLE.
//  6. combo preset to 254, a double hit (note 11 at bit 0, both keys pressed) -> combo=255, score +2. Further hits -> combo stays 255.

Source files
------------

// File: rtl/note_scroller_if.sv
// Chart-entry handshake between the chart ROM reader and the note scroller.
interface note_scroller_if;
  logic       valid;
  logic [1:0] note;
  logic       last;
  logic       ready;

  modport master (output valid, note, last, input ready);
  modport slave  (input valid, note, last, output ready);
endinterface

// File: rtl/note_scroller.sv
// Two-lane note scroller: shifts chart notes toward the hit slot on each tick,
// judges key presses at bit 0 and keeps a saturating score and combo.
module note_scroller #(
  parameter int unsigned LANE_LEN = 16,
  parameter int unsigned SCORE_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic                pause,
  note_scroller_if.slave      chart,
  input  logic                hit_red,
  input  logic                hit_blue,
  output logic [LANE_LEN-1:0] lane_red,
  output logic [LANE_LEN-1:0] lane_blue,
  output logic [SCORE_W-1:0]  score,
  output logic [7:0]          combo,
  output logic                hit_pulse,
  output logic                miss_pulse,
  output logic                done
);

  localparam int unsigned SUM_W   = SCORE_W + 1;
  localparam int unsigned COMBO_W = 8;

  typedef enum logic [2:0] {IDLE, RUN, PAUSED, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [LANE_LEN-1:0]   red_next, blue_next, red_kept, blue_kept;
  logic [SCORE_W-1:0]    score_next;
  logic [COMBO_W-1:0]    combo_next;
  logic                  hit_next, miss_next;
  logic                  judge, ins_red, ins_blue;
  logic                  hr, hb, mr, mb;
  logic [1:0]            hits;
  logic [SUM_W-1:0]      score_sum;
  logic [COMBO_W:0]      combo_sum;

  // Next-state, lane shifting and judging
  always_comb begin
    state_next  = state;
    red_next    = lane_red;
    blue_next   = lane_blue;
    score_next  = score;
    combo_next  = combo;
    hit_next    = 1'b0;
    miss_next   = 1'b0;
    chart.ready = 1'b0;
    judge       = 1'b0;
    ins_red     = 1'b0;
    ins_blue    = 1'b0;
    hr          = 1'b0;
    hb          = 1'b0;
    mr          = 1'b0;
    mb          = 1'b0;
    hits        = 2'd0;
    red_kept    = lane_red;
    blue_kept   = lane_blue;
    score_sum   = '0;
    combo_sum   = '0;

    case (state)
      IDLE, DONE: begin
        red_next  = '0;
        blue_next = '0;
        if (start) begin
          state_next = RUN;
          score_next = '0;
          combo_next = '0;
        end
      end
      RUN: begin
        // A pause in the same cycle as a tick freezes everything, including the chart.
        if (pause) begin
          state_next = PAUSED;
        end else begin
          judge       = 1'b1;
          chart.ready = tick;
          ins_red     = tick & chart.valid & chart.note[0];
          ins_blue    = tick & chart.valid & chart.note[1];
          if (tick && chart.valid && chart.last) state_next = DRAIN;
        end
      end
      PAUSED: begin
        if (pause) state_next = RUN;
      end
      DRAIN: begin
        judge = 1'b1;
        if (lane_red == '0 && lane_blue == '0) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase

    if (judge) begin
      hr        = hit_red  & lane_red[0];
      hb        = hit_blue & lane_blue[0];
      mr        = tick & lane_red[0]  & ~hit_red;
      mb        = tick & lane_blue[0] & ~hit_blue;
      hits      = 2'(hr) + 2'(hb);
      red_kept  = lane_red  & ~LANE_LEN'(hr);
      blue_kept = lane_blue & ~LANE_LEN'(hb);
      if (tick) begin
        red_next  = {ins_red,  red_kept[LANE_LEN-1:1]};
        blue_next = {ins_blue, blue_kept[LANE_LEN-1:1]};
      end else begin
        red_next  = red_kept;
        blue_next = blue_kept;
      end
      score_sum  = SUM_W'(score) + SUM_W'(hits);
      score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      combo_sum  = (COMBO_W+1)'(combo) + (COMBO_W+1)'(hits);
      if (mr || mb)              combo_next = '0;
      else if (combo_sum[COMBO_W]) combo_next = '1;
      else                       combo_next = combo_sum[COMBO_W-1:0];
      hit_next  = hr | hb;
      miss_next = mr | mb;
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lane_red   <= '0;
      lane_blue  <= '0;
      score      <= '0;
      combo      <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      lane_red   <= red_next;
      lane_blue  <= blue_next;
      score      <= score_next;
      combo      <= combo_next;
      hit_pulse  <= hit_next;
      miss_pulse <= miss_next;
      done       <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_note_scroller.sv
// Bench for note_scroller: directed vector table, saturation and reset sequences,
// then randomized traffic against a behavioural model.
module tb_note_scroller;
  localparam int unsigned LN = 4;
  localparam int unsigned SW = 8;
  localparam int SCORE_MAX = (1 << SW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          tick, start, pause, hit_red, hit_blue;
  logic [LN-1:0] lane_red, lane_blue;
  logic [SW-1:0] score;
  logic [7:0]    combo;
  logic          hit_pulse, miss_pulse, done;

  note_scroller_if chart();

  note_scroller #(.LANE_LEN(LN), .SCORE_W(SW)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .pause      (pause),
    .chart      (chart),
    .hit_red    (hit_red),
    .hit_blue   (hit_blue),
    .lane_red   (lane_red),
    .lane_blue  (lane_blue),
    .score      (score),
    .combo      (combo),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .done       (done)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: 0 idle, 1 run, 2 paused, 3 drain, 4 done
  int m_st;
  int m_red[LN];
  int m_blue[LN];
  int m_score, m_combo, m_hit, m_miss, m_done;

  task automatic model_reset();
    m_st = 0; m_score = 0; m_combo = 0; m_hit = 0; m_miss = 0; m_done = 0;
    for (int i = 0; i < LN; i++) begin m_red[i] = 0; m_blue[i] = 0; end
  endtask

  function automatic int m_ready(input int tk, input int ps);
    return (m_st == 1 && tk != 0 && ps == 0) ? 1 : 0;
  endfunction

  function automatic int red_val();
    int v = 0;
    for (int i = 0; i < LN; i++) v += m_red[i] << i;
    return v;
  endfunction

  function automatic int blue_val();
    int v = 0;
    for (int i = 0; i < LN; i++) v += m_blue[i] << i;
    return v;
  endfunction

  task automatic model_step(input int tk, st, ps, cv, cn, cl, hr, hb);
    int nxt = m_st;
    int hits = 0;
    int misses = 0;
    int judge = 0;
    int in_r = 0;
    int in_b = 0;
    m_hit = 0; m_miss = 0;
    case (m_st)
      0, 4: begin
        for (int i = 0; i < LN; i++) begin m_red[i] = 0; m_blue[i] = 0; end
        if (st != 0) begin nxt = 1; m_score = 0; m_combo = 0; end
      end
      1: if (ps != 0) nxt = 2;
         else begin
           judge = 1;
           if (tk != 0 && cv != 0) begin
             in_r = cn & 1; in_b = (cn >> 1) & 1;
             if (cl != 0) nxt = 3;
           end
         end
      2: if (ps != 0) nxt = 1;
      3: begin
        judge = 1;
        if (red_val() == 0 && blue_val() == 0) nxt = 4;
      end
      default: nxt = 0;
    endcase
    if (judge != 0) begin
      if (m_red[0] != 0) begin
        if (hr != 0) begin hits++; m_red[0] = 0; end
        else if (tk != 0) misses++;
      end
      if (m_blue[0] != 0) begin
        if (hb != 0) begin hits++; m_blue[0] = 0; end
        else if (tk != 0) misses++;
      end
      if (tk != 0) begin
        for (int i = 0; i < LN - 1; i++) begin m_red[i] = m_red[i+1]; m_blue[i] = m_blue[i+1]; end
        m_red[LN-1] = in_r; m_blue[LN-1] = in_b;
      end
      m_score = (m_score + hits > SCORE_MAX) ? SCORE_MAX : m_score + hits;
      m_combo = (misses != 0) ? 0 : ((m_combo + hits > 255) ? 255 : m_combo + hits);
      m_hit = (hits != 0) ? 1 : 0;
      m_miss = (misses != 0) ? 1 : 0;
    end
    m_st = nxt;
    m_done = (m_st == 4) ? 1 : 0;
  endtask

  // One clock: drive at negedge, sample chart_ready before the edge, outputs 1 after it
  task automatic step(input int tk, st, ps, cv, cn, cl, hr, hb, output int rdy, output int exp_rdy);
    @(negedge clock);
    tick = 1'(tk); start = 1'(st); pause = 1'(ps);
    chart.valid = 1'(cv); chart.note = 2'(cn); chart.last = 1'(cl);
    hit_red = 1'(hr); hit_blue = 1'(hb);
    #1;
    rdy = int'(chart.ready);
    exp_rdy = m_ready(tk, ps);
    @(posedge clock);
    model_step(tk, st, ps, cv, cn, cl, hr, hb);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " lane_red"},  int'(lane_red),  red_val());
    chk({tag, " lane_blue"}, int'(lane_blue), blue_val());
    chk({tag, " score"},     int'(score),     m_score);
    chk({tag, " combo"},     int'(combo),     m_combo);
    chk({tag, " hit_pulse"}, int'(hit_pulse), m_hit);
    chk({tag, " miss_pulse"},int'(miss_pulse),m_miss);
    chk({tag, " done"},      int'(done),      m_done);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    tick = 0; start = 0; pause = 0; hit_red = 0; hit_blue = 0;
    chart.valid = 0; chart.note = 2'd0; chart.last = 0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    int tk, st, ps, cv, cn, cl, hr, hb;
    int rdy, red, blue, sc, co, h, m, d;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input int tk, st, ps, cv, cn, cl, hr, hb,
                      input int rdy, red, blue, sc, co, h, m, d);
    vec_t v;
    v = '{tk, st, ps, cv, cn, cl, hr, hb, rdy, red, blue, sc, co, h, m, d};
    vecs.push_back(v);
  endtask

  initial begin
    int rdy, erdy;
    string nm;

    reset = 1'b1;
    tick = 0; start = 0; pause = 0; hit_red = 0; hit_blue = 0;
    chart.valid = 0; chart.note = 2'd0; chart.last = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset lanes", int'(lane_red) + int'(lane_blue), 0);
    chk("reset score_combo", int'(score) + int'(combo), 0);
    chk("reset flags", int'(hit_pulse) + int'(miss_pulse) + int'(done), 0);
    @(negedge clock);
    reset = 1'b0;

    //   tk st ps cv cn cl hr hb | rdy red     blue    sc co h m d
    addv(0, 1, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 1, 1, 1, 0, 0,   1, 4'b1000, 4'b0000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 1, 1, 0, 0, 0,   0, 4'b0100, 4'b0000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0010, 4'b0000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 1,   0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 1, 0,   0, 4'b0000, 4'b0000, 1, 1, 1, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 1, 1, 0, 0, 1);
    addv(0, 1, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 1, 2, 0, 0, 0,   1, 4'b0000, 4'b1000, 0, 0, 0, 0, 0);
    addv(1, 0, 1, 1, 1, 0, 0, 0,   0, 4'b0000, 4'b1000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 1, 1, 0, 0, 0,   0, 4'b0000, 4'b1000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 1,   0, 4'b0000, 4'b1000, 0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b1000, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b1000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 0,   1, 4'b0000, 4'b0100, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 1, 3, 0, 0, 0,   1, 4'b1000, 4'b1010, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 0,   1, 4'b0100, 4'b0101, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 1,   1, 4'b0010, 4'b0010, 1, 1, 1, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 0,   1, 4'b0001, 4'b0001, 1, 1, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 1, 0,   1, 4'b0000, 4'b0000, 2, 0, 1, 1, 0);
    addv(1, 0, 0, 1, 0, 1, 0, 0,   1, 4'b0000, 4'b0000, 2, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 2, 0, 0, 0, 1);
    addv(0, 1, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 1, 1, 1, 0, 0,   1, 4'b1000, 4'b0000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0100, 4'b0000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0010, 4'b0000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 1,   0, 4'b0000, 4'b0000, 0, 0, 0, 1, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].tk, vecs[i].st, vecs[i].ps, vecs[i].cv, vecs[i].cn, vecs[i].cl,
           vecs[i].hr, vecs[i].hb, rdy, erdy);
      nm = $sformatf("vec%0d", i);
      chk({nm, " chart_ready"}, rdy, vecs[i].rdy);
      chk({nm, " lane_red"},    int'(lane_red),  vecs[i].red);
      chk({nm, " lane_blue"},   int'(lane_blue), vecs[i].blue);
      chk({nm, " score"},       int'(score),     vecs[i].sc);
      chk({nm, " combo"},       int'(combo),     vecs[i].co);
      chk({nm, " hit_pulse"},   int'(hit_pulse), vecs[i].h);
      chk({nm, " miss_pulse"},  int'(miss_pulse),vecs[i].m);
      chk({nm, " done"},        int'(done),      vecs[i].d);
    end

    // Asynchronous reset mid-song
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0, rdy, erdy);
    step(1, 0, 0, 1, 1, 0, 0, 0, rdy, erdy);
    chk("pre-reset lane_red", int'(lane_red), 4'b1000);
    #2;
    reset = 1'b1;
    tick = 1'b1;
    #1;
    chk("async reset lane_red", int'(lane_red), 0);
    chk("async reset ready", int'(chart.ready), 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(1, 0, 0, 1, 3, 0, 0, 0, rdy, erdy);
    chk("idle after reset ready", rdy, 0);
    chk("idle after reset lanes", int'(lane_red) + int'(lane_blue), 0);

    // Combo and score saturation via repeated double hits
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0, rdy, erdy);
    repeat (LN) step(1, 0, 0, 1, 3, 0, 0, 0, rdy, erdy);
    repeat (127) step(1, 0, 0, 1, 3, 0, 1, 1, rdy, erdy);
    chk("sat combo 254", int'(combo), 254);
    chk("sat score 254", int'(score), 254);
    step(1, 0, 0, 1, 3, 0, 1, 1, rdy, erdy);
    chk("sat combo 255", int'(combo), 255);
    chk("sat score 255", int'(score), 255);
    chk("sat hit_pulse", int'(hit_pulse), 1);
    step(1, 0, 0, 1, 3, 0, 1, 1, rdy, erdy);
    chk("sat combo hold", int'(combo), 255);
    chk("sat score hold", int'(score), 255);
    check_model("sat");

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int tk, st, ps, cv, cn, cl, hr, hb;
      tk = ($urandom % 3 == 0) ? 1 : 0;
      st = ($urandom % 40 == 0) ? 1 : 0;
      ps = ($urandom % 30 == 0) ? 1 : 0;
      cv = ($urandom % 4 != 0) ? 1 : 0;
      cn = int'($urandom % 4);
      cl = ($urandom % 25 == 0) ? 1 : 0;
      hr = ($urandom % 3 == 0) ? 1 : 0;
      hb = ($urandom % 3 == 0) ? 1 : 0;
      step(tk, st, ps, cv, cn, cl, hr, hb, rdy, erdy);
      chk("rand chart_ready", rdy, erdy);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
